cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_tag_cmp.sv | 21 ++
 rtl/cache_control.sv | 171 +++++++++++++++++
 tb/tb_cache_control.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field widths for the two-way cache controller.
package cache_pkg;

    localparam int INDEX_W  = 3;
    localparam int OFFSET_W = 5;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        ALLOCATE
    } state_t;

endpackage

// File: rtl/cache_tag_cmp.sv
// Two-way tag comparator. Way 0 takes priority when both ways match.
module cache_tag_cmp #(
    parameter int TAG_W = cache_pkg::TAG_W
) (
    input  logic [TAG_W-1:0] mem_tag,
    input  logic [TAG_W-1:0] tag0,
    input  logic [TAG_W-1:0] tag1,
    input  logic             valid0,
    input  logic             valid1,
    output logic             hit0,
    output logic             hit1,
    output logic             hit,
    output logic             hit_way
);

    assign hit0    = valid0 & (tag0 == mem_tag);
    assign hit1    = valid1 & (tag1 == mem_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = ~hit0 & hit1;

endmodule

// File: rtl/cache_control.sv
// Two-way set-associative cache control FSM with write-back, LRU update and
// hit/miss performance counters.
module cache_control #(
    parameter int TAG_W = cache_pkg::TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic [TAG_W-1:0] tag0,
    input  logic [TAG_W-1:0] tag1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             lru,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic             way_sel,
    output logic             data_in_sel,
    output logic             load_data0,
    output logic             load_data1,
    output logic             load_tag0,
    output logic             load_tag1,
    output logic             load_valid0,
    output logic             load_valid1,
    output logic             load_dirty0,
    output logic             load_dirty1,
    output logic             load_lru,
    output logic             valid_in,
    output logic             dirty_in,
    output logic             lru_in,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    import cache_pkg::*;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_miss_count;
    logic             r_retry;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic             w_hit_way;
    logic             w_victim;
    logic             w_victim_dirty;
    logic             w_pmem_done;
    logic             w_hit_inc;
    logic             w_miss_inc;

    cache_tag_cmp #(.TAG_W(TAG_W)) u_tag_cmp (
        .mem_tag (mem_tag),
        .tag0    (tag0),
        .tag1    (tag1),
        .valid0  (valid0),
        .valid1  (valid1),
        .hit0    (w_hit0),
        .hit1    (w_hit1),
        .hit     (w_hit),
        .hit_way (w_hit_way)
    );

    assign w_victim       = lru;
    assign w_victim_dirty = w_victim ? (valid1 & dirty1) : (valid0 & dirty0);
    // A line arriving in the reset cycle must not be written into the arrays.
    assign w_pmem_done    = pmem_resp & ~rst;
    assign hit_count      = r_hit_count;
    assign miss_count     = r_miss_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_retry      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_hit_inc)  r_hit_count  <= r_hit_count + 1'b1;
            if (w_miss_inc) r_miss_count <= r_miss_count + 1'b1;
            if (r_state == ALLOCATE && w_pmem_done) r_retry <= 1'b1;
            else if (r_state == CHECK)              r_retry <= 1'b0;
        end
    end

    // NOTE: every output gets a default before the case so no latch is
    // inferred and unnamed strobes stay low in each state.
    always_comb begin
        w_next_state  = r_state;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 1'b0;
        data_in_sel   = 1'b0;
        load_data0    = 1'b0;
        load_data1    = 1'b0;
        load_tag0     = 1'b0;
        load_tag1     = 1'b0;
        load_valid0   = 1'b0;
        load_valid1   = 1'b0;
        load_dirty0   = 1'b0;
        load_dirty1   = 1'b0;
        load_lru      = 1'b0;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        lru_in        = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_read | mem_write) w_next_state = CHECK;
            end
            CHECK: begin
                if (w_hit) begin
                    mem_resp     = 1'b1;
                    load_lru     = 1'b1;
                    lru_in       = ~w_hit_way;
                    way_sel      = w_hit_way;
                    w_hit_inc    = ~r_retry;
                    w_next_state = IDLE;
                    if (mem_write) begin
                        data_in_sel = 1'b0;
                        dirty_in    = 1'b1;
                        load_data0  = ~w_hit_way;
                        load_data1  = w_hit_way;
                        load_dirty0 = ~w_hit_way;
                        load_dirty1 = w_hit_way;
                    end
                end else begin
                    w_miss_inc   = 1'b1;
                    w_next_state = w_victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = w_victim;
                if (pmem_resp) w_next_state = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (w_pmem_done) begin
                    way_sel      = w_victim;
                    data_in_sel  = 1'b1;
                    valid_in     = 1'b1;
                    load_data0   = ~w_victim;
                    load_data1   = w_victim;
                    load_tag0    = ~w_victim;
                    load_tag1    = w_victim;
                    load_valid0  = ~w_victim;
                    load_valid1  = w_victim;
                    load_dirty0  = ~w_victim;
                    load_dirty1  = w_victim;
                    w_next_state = CHECK;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control; a narrow-counter instance
// shares the stimulus to exercise counter wrap-around in a short run.
module tb_cache_control;

    localparam int TAG_W = 24;

    localparam logic [17:0] O_RESP  = 18'b1 << 17;
    localparam logic [17:0] O_PREAD = 18'b1 << 16;
    localparam logic [17:0] O_PWR   = 18'b1 << 15;
    localparam logic [17:0] O_ASEL  = 18'b1 << 14;
    localparam logic [17:0] O_WAY   = 18'b1 << 13;
    localparam logic [17:0] O_DSEL  = 18'b1 << 12;
    localparam logic [17:0] O_LD0   = 18'b1 << 11;
    localparam logic [17:0] O_LD1   = 18'b1 << 10;
    localparam logic [17:0] O_LT0   = 18'b1 << 9;
    localparam logic [17:0] O_LT1   = 18'b1 << 8;
    localparam logic [17:0] O_LV0   = 18'b1 << 7;
    localparam logic [17:0] O_LV1   = 18'b1 << 6;
    localparam logic [17:0] O_LDD0  = 18'b1 << 5;
    localparam logic [17:0] O_LDD1  = 18'b1 << 4;
    localparam logic [17:0] O_LLRU  = 18'b1 << 3;
    localparam logic [17:0] O_VIN   = 18'b1 << 2;
    localparam logic [17:0] O_DIN   = 18'b1 << 1;
    localparam logic [17:0] O_LRUIN = 18'b1;

    logic             clk;
    logic             rst;
    logic             mem_read, mem_write;
    logic [TAG_W-1:0] mem_tag, tag0, tag1;
    logic             valid0, valid1, dirty0, dirty1, lru, pmem_resp;
    logic             mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_in_sel;
    logic             load_data0, load_data1, load_tag0, load_tag1;
    logic             load_valid0, load_valid1, load_dirty0, load_dirty1, load_lru;
    logic             valid_in, dirty_in, lru_in;
    logic [15:0]      hit_count, miss_count;
    logic [17:0]      outs;

    logic             n_mem_resp, n_pmem_read, n_pmem_write, n_pmem_addr_sel, n_way_sel;
    logic             n_data_in_sel, n_load_data0, n_load_data1, n_load_tag0, n_load_tag1;
    logic             n_load_valid0, n_load_valid1, n_load_dirty0, n_load_dirty1, n_load_lru;
    logic             n_valid_in, n_dirty_in, n_lru_in;
    logic [3:0]       n_hit_count, n_miss_count;

    int n_cmp = 0;
    int n_err = 0;

    assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, data_in_sel,
                   load_data0, load_data1, load_tag0, load_tag1, load_valid0, load_valid1,
                   load_dirty0, load_dirty1, load_lru, valid_in, dirty_in, lru_in};

    cache_control #(.TAG_W(TAG_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_tag(mem_tag), .tag0(tag0), .tag1(tag1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel), .data_in_sel(data_in_sel),
        .load_data0(load_data0), .load_data1(load_data1), .load_tag0(load_tag0),
        .load_tag1(load_tag1), .load_valid0(load_valid0), .load_valid1(load_valid1),
        .load_dirty0(load_dirty0), .load_dirty1(load_dirty1), .load_lru(load_lru),
        .valid_in(valid_in), .dirty_in(dirty_in), .lru_in(lru_in),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_control #(.TAG_W(TAG_W), .CNT_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_tag(mem_tag), .tag0(tag0), .tag1(tag1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru(lru), .pmem_resp(pmem_resp),
        .mem_resp(n_mem_resp), .pmem_read(n_pmem_read), .pmem_write(n_pmem_write),
        .pmem_addr_sel(n_pmem_addr_sel), .way_sel(n_way_sel), .data_in_sel(n_data_in_sel),
        .load_data0(n_load_data0), .load_data1(n_load_data1), .load_tag0(n_load_tag0),
        .load_tag1(n_load_tag1), .load_valid0(n_load_valid0), .load_valid1(n_load_valid1),
        .load_dirty0(n_load_dirty0), .load_dirty1(n_load_dirty1), .load_lru(n_load_lru),
        .valid_in(n_valid_in), .dirty_in(n_dirty_in), .lru_in(n_lru_in),
        .hit_count(n_hit_count), .miss_count(n_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change 2 time units after the edge, checks 1 later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_cmp++; if (outs !== 18'd0) begin n_err++; $display("FAIL reset_outs: got %h want %h", outs, 18'd0); end
        n_cmp++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_err++; $display("FAIL reset_counters: got hit %0d miss %0d want 0 0", hit_count, miss_count); end
        n_cmp++; if (dut.r_state !== cache_pkg::IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dut.r_state); end
    endtask

    task automatic test_miss_allocate();
        mem_read = 1'b1; mem_tag = 24'h000001; lru = 1'b0;
        #1;
        n_cmp++; if (outs !== 18'd0) begin n_err++; $display("FAIL alloc_idle_outs: got %h want %h", outs, 18'd0); end
        tick(); #1;
        n_cmp++; if (outs !== 18'd0) begin n_err++; $display("FAIL alloc_check_miss: got %h want %h", outs, 18'd0); end
        tick(); #1;
        n_cmp++; if (outs !== O_PREAD) begin n_err++; $display("FAIL alloc_pread: got %h want %h", outs, O_PREAD); end
        n_cmp++; if (miss_count !== 16'd1) begin n_err++; $display("FAIL alloc_miss_count: got %0d want 1", miss_count); end
        tick(); #1;
        n_cmp++; if (outs !== O_PREAD) begin n_err++; $display("FAIL alloc_hold: got %h want %h", outs, O_PREAD); end
        pmem_resp = 1'b1; #1;
        n_cmp++; if (outs !== (O_PREAD|O_DSEL|O_LD0|O_LT0|O_LV0|O_LDD0|O_VIN)) begin n_err++; $display("FAIL alloc_load0: got %h want %h", outs, O_PREAD|O_DSEL|O_LD0|O_LT0|O_LV0|O_LDD0|O_VIN); end
        tick();
        pmem_resp = 1'b0; tag0 = 24'h000001; valid0 = 1'b1; dirty0 = 1'b0; #1;
        n_cmp++; if (outs !== (O_RESP|O_LLRU|O_LRUIN)) begin n_err++; $display("FAIL alloc_retry_resp: got %h want %h", outs, O_RESP|O_LLRU|O_LRUIN); end
        tick();
        mem_read = 1'b0; #1;
        n_cmp++; if (hit_count !== 16'd0 || miss_count !== 16'd1) begin n_err++; $display("FAIL alloc_counters: got hit %0d miss %0d want 0 1", hit_count, miss_count); end
    endtask

    task automatic test_read_hit_way1();
        tag1 = 24'h000055; valid1 = 1'b1; dirty1 = 1'b0; lru = 1'b1;
        mem_read = 1'b1; mem_tag = 24'h000055; #1;
        n_cmp++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL rhit_no_early_resp: got %b want 0", mem_resp); end
        tick(); #1;
        n_cmp++; if (outs !== (O_RESP|O_WAY|O_LLRU)) begin n_err++; $display("FAIL rhit_way1: got %h want %h", outs, O_RESP|O_WAY|O_LLRU); end
        tick();
        mem_read = 1'b0; #1;
        n_cmp++; if (hit_count !== 16'd1) begin n_err++; $display("FAIL rhit_count: got %0d want 1", hit_count); end
        n_cmp++; if (outs !== 18'd0) begin n_err++; $display("FAIL rhit_idle_outs: got %h want %h", outs, 18'd0); end
    endtask

    task automatic test_write_hit_way0();
        // Both ways match and both strobes are high: way 0 must win and it is a write.
        tag1 = 24'h000001; valid1 = 1'b1;
        mem_read = 1'b1; mem_write = 1'b1; mem_tag = 24'h000001;
        tick(); #1;
        n_cmp++; if (outs !== (O_RESP|O_LLRU|O_LRUIN|O_LD0|O_LDD0|O_DIN)) begin n_err++; $display("FAIL whit_way0: got %h want %h", outs, O_RESP|O_LLRU|O_LRUIN|O_LD0|O_LDD0|O_DIN); end
        tick();
        mem_read = 1'b0; mem_write = 1'b0; dirty0 = 1'b1; tag1 = 24'h000055; #1;
        n_cmp++; if (hit_count !== 16'd2) begin n_err++; $display("FAIL whit_count: got %0d want 2", hit_count); end
    endtask

    task automatic test_dirty_writeback();
        lru = 1'b0; mem_read = 1'b1; mem_tag = 24'h000077;
        tick(); #1;
        n_cmp++; if (outs !== 18'd0) begin n_err++; $display("FAIL wb_check_miss: got %h want %h", outs, 18'd0); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            n_cmp++; if (outs !== (O_PWR|O_ASEL)) begin n_err++; $display("FAIL wb_pwrite_%0d: got %h want %h", i, outs, O_PWR|O_ASEL); end
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; #1;
        n_cmp++; if (outs !== O_PREAD) begin n_err++; $display("FAIL wb_then_pread: got %h want %h", outs, O_PREAD); end
        n_cmp++; if (miss_count !== 16'd2) begin n_err++; $display("FAIL wb_miss_count: got %0d want 2", miss_count); end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; tag0 = 24'h000077; dirty0 = 1'b0; #1;
        n_cmp++; if (outs !== (O_RESP|O_LLRU|O_LRUIN)) begin n_err++; $display("FAIL wb_final_resp: got %h want %h", outs, O_RESP|O_LLRU|O_LRUIN); end
        tick();
        mem_read = 1'b0; #1;
        n_cmp++; if (hit_count !== 16'd2) begin n_err++; $display("FAIL wb_hit_count: got %0d want 2", hit_count); end
    endtask

    task automatic test_reset_mid_writeback();
        dirty1 = 1'b1; lru = 1'b1; mem_write = 1'b1; mem_tag = 24'h000099;
        tick();
        tick(); #1;
        n_cmp++; if (outs !== (O_PWR|O_ASEL|O_WAY)) begin n_err++; $display("FAIL rwb_victim1: got %h want %h", outs, O_PWR|O_ASEL|O_WAY); end
        tick();
        rst = 1'b1; pmem_resp = 1'b1;
        tick();
        rst = 1'b0; pmem_resp = 1'b0; mem_write = 1'b0; #1;
        n_cmp++; if (outs !== 18'd0) begin n_err++; $display("FAIL rwb_outs: got %h want %h", outs, 18'd0); end
        n_cmp++; if (dut.r_state !== cache_pkg::IDLE) begin n_err++; $display("FAIL rwb_state: got %0d want IDLE", dut.r_state); end
        n_cmp++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_err++; $display("FAIL rwb_counters: got hit %0d miss %0d want 0 0", hit_count, miss_count); end
    endtask

    task automatic test_reset_mid_allocate();
        lru = 1'b0; mem_read = 1'b1; mem_tag = 24'h000088;
        tick();
        tick(); #1;
        n_cmp++; if (outs !== O_PREAD) begin n_err++; $display("FAIL ralloc_pread: got %h want %h", outs, O_PREAD); end
        rst = 1'b1; pmem_resp = 1'b1; #1;
        n_cmp++; if (outs !== O_PREAD) begin n_err++; $display("FAIL ralloc_resp_ignored: got %h want %h", outs, O_PREAD); end
        tick();
        rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0; #1;
        n_cmp++; if (dut.r_state !== cache_pkg::IDLE) begin n_err++; $display("FAIL ralloc_state: got %0d want IDLE", dut.r_state); end
        n_cmp++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL ralloc_miss: got %0d want 0", miss_count); end
    endtask

    task automatic test_counter_wrap();
        mem_read = 1'b1; mem_tag = 24'h000055;
        for (int i = 0; i < 15; i++) begin
            tick();
            tick();
        end
        #1;
        n_cmp++; if (n_hit_count !== 4'd15 || hit_count !== 16'd15) begin n_err++; $display("FAIL wrap_pre: got narrow %0d wide %0d want 15 15", n_hit_count, hit_count); end
        tick();
        tick();
        mem_read = 1'b0; #1;
        n_cmp++; if (n_hit_count !== 4'd0) begin n_err++; $display("FAIL wrap_narrow: got %0d want 0", n_hit_count); end
        n_cmp++; if (hit_count !== 16'd16) begin n_err++; $display("FAIL wrap_wide: got %0d want 16", hit_count); end
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_tag = '0;
        tag0 = '0; tag1 = '0; valid0 = 1'b0; valid1 = 1'b0;
        dirty0 = 1'b0; dirty1 = 1'b0; lru = 1'b0; pmem_resp = 1'b0;
        test_reset();
        test_miss_allocate();
        test_read_hit_way1();
        test_write_hit_way0();
        test_dirty_writeback();
        test_reset_mid_writeback();
        test_reset_mid_allocate();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
